// File: rtl/apb_timer_s.sv
// apb_timer_s - APB responder wrapping a 16-bit down-counting timer.
//
// Sits on one select slot of an APB interconnect and decodes only S_PADDR[3:0].
// The counter ticks once every PRESCALE S_PCLK cycles while enabled. It
// optionally auto-reloads from LOAD, and it raises a level interrupt while the
// expiry flag and the interrupt enable are both set.
//
// Ports:
//   S_PCLK     bus clock, all state changes on its rising edge
//   S_PRESET   synchronous active-high reset
//   S_PADDR    address, only [3:0] decoded
//   S_PWRITE   1 = write, 0 = read
//   S_PSELx    slot select
//   S_PENABLE  APB access-phase marker
//   S_PWDATA   write data
//   S_PRDATA   registered read data, 0 outside a read completion
//   S_PREADY   registered transfer completion, one cycle wide
//   IRQ        registered level interrupt (EXP & IE)
//   S_PSLVERR  only with APB_TIMER_PSLVERR_EN: error flag for unmapped offsets
//              and for STAT writes with bit0 = 0
//
// Register map (offset S_PADDR[3:0]):
//   0 CTRL  [0] EN, [1] AUTO, [2] IE
//   1 LOAD  reload value
//   2 VALUE current count, writable
//   3 STAT  [0] EXP, write-1-to-clear
//   4-15    read 0, writes ignored
//
// Optional feature macro: APB_TIMER_PSLVERR_EN
//
// Bus FSM:
//   state | meaning
//   IDLE  | no transfer in progress, waiting for a setup phase
//   WAIT  | access phase with PREADY low, counting down the wait states
//   DONE  | PREADY high for one cycle, write commits at the closing edge
module apb_timer_s #(
    parameter int BUS_WIDTH   = 16,
    parameter int PRESCALE    = 4,
    parameter int WAIT_STATES = 1
) (
    input  logic                 S_PCLK,
    input  logic                 S_PRESET,
    input  logic [BUS_WIDTH-1:0] S_PADDR,
    input  logic                 S_PWRITE,
    input  logic                 S_PSELx,
    input  logic                 S_PENABLE,
    input  logic [BUS_WIDTH-1:0] S_PWDATA,
    output logic [BUS_WIDTH-1:0] S_PRDATA,
    output logic                 S_PREADY,
`ifdef APB_TIMER_PSLVERR_EN
    output logic                 S_PSLVERR,
`endif
    output logic                 IRQ
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    localparam logic [BUS_WIDTH-1:0] PSC_MAX = BUS_WIDTH'(PRESCALE - 1);

    state_t               r_state;
    state_t               w_next;
    logic [2:0]           r_wcnt;
    logic [2:0]           w_wcnt_next;

    logic                 r_en;
    logic                 r_auto;
    logic                 r_ie;
    logic                 r_exp;
    logic [BUS_WIDTH-1:0] r_load;
    logic [BUS_WIDTH-1:0] r_value;
    logic [BUS_WIDTH-1:0] r_psc;
    logic [BUS_WIDTH-1:0] r_prdata;
    logic                 r_pready;
    logic                 r_irq;
    logic                 r_slverr;

    logic [3:0]           w_off;
    logic                 w_enter_done;
    logic                 w_commit;
    logic                 w_wr_ctrl;
    logic                 w_wr_load;
    logic                 w_wr_value;
    logic                 w_wr_stat;
    logic                 w_tick;
    logic                 w_expire;
    logic                 w_slverr;
    logic [BUS_WIDTH-1:0] w_rdata;
    logic                 w_unused_addr;

    assign w_off         = S_PADDR[3:0];
    assign w_unused_addr = ^S_PADDR[BUS_WIDTH-1:4];

    always_comb begin
        w_next      = r_state;
        w_wcnt_next = r_wcnt;
        case (r_state)
            ST_IDLE: begin
                if (S_PSELx && !S_PENABLE) begin
                    if (WAIT_STATES == 0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next      = ST_WAIT;
                        w_wcnt_next = 3'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                if (!S_PSELx) begin
                    w_next = ST_IDLE;
                end else if (S_PENABLE) begin
                    // The decrement that reaches zero is the one that completes the wait.
                    if (r_wcnt <= 3'd1) begin
                        w_next      = ST_DONE;
                        w_wcnt_next = 3'd0;
                    end else begin
                        w_wcnt_next = r_wcnt - 3'd1;
                    end
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_enter_done = (w_next == ST_DONE) && (r_state != ST_DONE);
    assign w_commit     = (r_state == ST_DONE) && S_PSELx && S_PENABLE && S_PWRITE;
    assign w_wr_ctrl    = w_commit && (w_off == 4'd0);
    assign w_wr_load    = w_commit && (w_off == 4'd1);
    assign w_wr_value   = w_commit && (w_off == 4'd2);
    assign w_wr_stat    = w_commit && (w_off == 4'd3);

    assign w_tick   = r_en && (r_psc == PSC_MAX);
    assign w_expire = w_tick && (r_value == '0);
    assign w_slverr = (w_off >= 4'd4) || (S_PWRITE && (w_off == 4'd3) && !S_PWDATA[0]);

    always_comb begin
        w_rdata = '0;
        case (w_off)
            4'd0:    w_rdata = {{(BUS_WIDTH-3){1'b0}}, r_ie, r_auto, r_en};
            4'd1:    w_rdata = r_load;
            4'd2:    w_rdata = r_value;
            4'd3:    w_rdata = {{(BUS_WIDTH-1){1'b0}}, r_exp};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge S_PCLK) begin
        if (S_PRESET) begin
            r_state  <= ST_IDLE;
            r_wcnt   <= '0;
            r_en     <= 1'b0;
            r_auto   <= 1'b0;
            r_ie     <= 1'b0;
            r_exp    <= 1'b0;
            r_load   <= '0;
            r_value  <= '0;
            r_psc    <= '0;
            r_prdata <= '0;
            r_pready <= 1'b0;
            r_irq    <= 1'b0;
            r_slverr <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_wcnt   <= w_wcnt_next;
            r_pready <= w_enter_done;
            r_prdata <= (w_enter_done && !S_PWRITE) ? w_rdata : '0;
            r_slverr <= w_enter_done && w_slverr;

            // Any CTRL write restarts the prescale period, whatever EN becomes.
            if (w_wr_ctrl) begin
                r_psc <= '0;
            end else if (r_en) begin
                r_psc <= w_tick ? '0 : r_psc + BUS_WIDTH'(1);
            end

            if (w_wr_ctrl) begin
                r_en   <= S_PWDATA[0];
                r_auto <= S_PWDATA[1];
                r_ie   <= S_PWDATA[2];
            end else if (w_expire && !r_auto) begin
                r_en <= 1'b0;
            end

            if (w_wr_load) begin
                r_load <= S_PWDATA;
            end

            // A direct VALUE write takes priority, so the tick in that cycle is lost.
            if (w_wr_value) begin
                r_value <= S_PWDATA;
            end else if (w_tick) begin
                if (r_value != '0) begin
                    r_value <= r_value - BUS_WIDTH'(1);
                end else if (r_auto) begin
                    r_value <= r_load;
                end
            end

            // Expiry beats a simultaneous write-1-to-clear.
            if (w_expire) begin
                r_exp <= 1'b1;
            end else if (w_wr_stat && S_PWDATA[0]) begin
                r_exp <= 1'b0;
            end

            r_irq <= r_exp && r_ie;
        end
    end

    assign S_PRDATA = r_prdata;
    assign S_PREADY = r_pready;
    assign IRQ      = r_irq;
`ifdef APB_TIMER_PSLVERR_EN
    assign S_PSLVERR = r_slverr;
`else
    logic w_unused_slverr;
    assign w_unused_slverr = r_slverr;
`endif

endmodule

// File: tb/tb_apb_timer_s.sv
module tb_apb_timer_s;

    logic        clk = 1'b0;
    logic        preset;
    logic [15:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready;
    logic        irq;
`ifdef APB_TIMER_PSLVERR_EN
    logic        pslverr;
    logic        last_slverr;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    apb_timer_s #(.BUS_WIDTH(16), .PRESCALE(4), .WAIT_STATES(1)) dut (
        .S_PCLK    (clk),
        .S_PRESET  (preset),
        .S_PADDR   (paddr),
        .S_PWRITE  (pwrite),
        .S_PSELx   (psel),
        .S_PENABLE (penable),
        .S_PWDATA  (pwdata),
        .S_PRDATA  (prdata),
        .S_PREADY  (pready),
`ifdef APB_TIMER_PSLVERR_EN
        .S_PSLVERR (pslverr),
`endif
        .IRQ       (irq)
    );

    // One complete APB transfer. Edges inside: P0 (setup driven after it), P1
    // (access driven after it), P2 (PREADY rises), P3 (write commits).
    // lat counts negedges from the access phase until PREADY is seen high;
    // extra is PREADY one cycle after that.
    task automatic apb_xfer(input logic [3:0] off, input logic wr, input logic [15:0] wdata,
                            output logic [15:0] rdata, output int lat, output logic extra);
        rdata = '0;
        lat   = -1;
        extra = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = {12'h000, off}; pwrite = wr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (pready === 1'b1) begin
                lat   = i;
                rdata = prdata;
`ifdef APB_TIMER_PSLVERR_EN
                last_slverr = pslverr;
`endif
                break;
            end
        end
        if (lat < 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL xfer_timeout off=%0h: PREADY not seen within 16 cycles", off);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        extra = pready;
    endtask

    task automatic apb_write(input logic [3:0] off, input logic [15:0] wdata);
        logic [15:0] rd;
        int          lat;
        logic        ex;
        apb_xfer(off, 1'b1, wdata, rd, lat, ex);
    endtask

    task automatic apb_read(input logic [3:0] off, output logic [15:0] rdata);
        int   lat;
        logic ex;
        apb_xfer(off, 1'b0, 16'h0000, rdata, lat, ex);
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        int          lat;
        logic        ex;
        preset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (pready !== 1'b0 || prdata !== 16'h0000 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got pready=%b prdata=%h irq=%b expected 0/0000/0", pready, prdata, irq);
        end
        @(posedge clk); #1;
        preset = 1'b0;
        for (int off = 0; off < 4; off++) begin
            apb_xfer(4'(off), 1'b0, 16'h0000, rd, lat, ex);
            tests_run++;
            if (rd !== 16'h0000 || lat != 2 || ex !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_read off=%0d: got data=%h lat=%0d pready_after=%b expected 0000/2/0",
                         off, rd, lat, ex);
            end
        end
        tests_run++;
        if (prdata !== 16'h0000 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_read: got prdata=%h irq=%b expected 0000/0", prdata, irq);
        end
    endtask

    task automatic test_autoreload();
        logic [15:0] rd;
        int          lat;
        logic        ex;
        logic [15:0] exp_v [3];
        exp_v[0] = 16'h0002;
        exp_v[1] = 16'h0001;
        exp_v[2] = 16'h0000;
        apb_write(4'd1, 16'h0003);
        apb_write(4'd2, 16'h0003);
        // CTRL commits at edge C; ticks at C+4k.
        apb_xfer(4'd0, 1'b1, 16'h0007, rd, lat, ex);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL write_prdata: got %h expected 0000", rd);
        end
        repeat (3) @(posedge clk);
        // Captures at C+6, C+10, C+14.
        for (int k = 0; k < 3; k++) begin
            apb_read(4'd2, rd);
            tests_run++;
            if (rd !== exp_v[k]) begin
                tests_failed++;
                $display("FAIL auto_count[%0d]: got %h expected %h", k, rd, exp_v[k]);
            end
        end
        // Expiry at C+16, IRQ visible after C+17.
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_before_expiry: got %b expected 0", irq);
        end
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_same_cycle_as_exp: got %b expected 0", irq);
        end
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_after_exp: got %b expected 1", irq);
        end
        apb_read(4'd2, rd);
        tests_run++;
        if (rd !== 16'h0003) begin
            tests_failed++;
            $display("FAIL reload_value: got %h expected 0003", rd);
        end
        apb_read(4'd3, rd);
        tests_run++;
        if (rd !== 16'h0001) begin
            tests_failed++;
            $display("FAIL auto_exp: got %h expected 0001", rd);
        end
        apb_write(4'd0, 16'h0000);
    endtask

    task automatic test_oneshot();
        logic [15:0] rd;
        apb_write(4'd3, 16'h0001);
        apb_write(4'd2, 16'h0001);
        apb_write(4'd0, 16'h0001);
        repeat (10) @(posedge clk);
        apb_read(4'd0, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL oneshot_ctrl: got %h expected 0000", rd);
        end
        apb_read(4'd2, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL oneshot_value: got %h expected 0000", rd);
        end
        apb_read(4'd3, rd);
        tests_run++;
        if (rd !== 16'h0001 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL oneshot_exp_irq: got exp=%h irq=%b expected 0001/0", rd, irq);
        end
    endtask

    task automatic test_w1c_race();
        logic [15:0] rd;
        apb_write(4'd3, 16'h0001);
        apb_write(4'd2, 16'h0000);
        apb_write(4'd0, 16'h0005);
        // Commits at C+4, the edge where the zero count expires.
        apb_write(4'd3, 16'h0001);
        apb_read(4'd3, rd);
        tests_run++;
        if (rd !== 16'h0001) begin
            tests_failed++;
            $display("FAIL w1c_vs_expiry: got %h expected 0001", rd);
        end
        apb_write(4'd3, 16'h0001);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_at_clear_edge: got %b expected 1", irq);
        end
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_after_clear: got %b expected 0", irq);
        end
        apb_read(4'd3, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL exp_cleared: got %h expected 0000", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd;
        // LOAD write on the auto-reload edge: reload uses the old LOAD.
        apb_write(4'd2, 16'h0000);
        apb_write(4'd1, 16'h0007);
        apb_write(4'd0, 16'h0003);
        apb_write(4'd1, 16'h0009);
        apb_read(4'd2, rd);
        tests_run++;
        if (rd !== 16'h0007) begin
            tests_failed++;
            $display("FAIL load_vs_reload: got %h expected 0007", rd);
        end
        apb_write(4'd0, 16'h0000);
        apb_read(4'd1, rd);
        tests_run++;
        if (rd !== 16'h0009) begin
            tests_failed++;
            $display("FAIL load_written: got %h expected 0009", rd);
        end
        // CTRL clearing EN on the expiry edge: EXP still sets.
        apb_write(4'd3, 16'h0001);
        apb_write(4'd2, 16'h0000);
        apb_write(4'd0, 16'h0001);
        apb_write(4'd0, 16'h0000);
        apb_read(4'd3, rd);
        tests_run++;
        if (rd !== 16'h0001) begin
            tests_failed++;
            $display("FAIL ctrl_vs_expiry_exp: got %h expected 0001", rd);
        end
        apb_read(4'd0, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL ctrl_vs_expiry_en: got %h expected 0000", rd);
        end
        // VALUE write on a tick edge: the write wins.
        apb_write(4'd2, 16'h0010);
        apb_write(4'd0, 16'h0001);
        apb_write(4'd2, 16'h00FF);
        apb_read(4'd2, rd);
        tests_run++;
        if (rd !== 16'h00FF) begin
            tests_failed++;
            $display("FAIL value_vs_tick: got %h expected 00ff", rd);
        end
        apb_write(4'd0, 16'h0000);
        apb_write(4'd9, 16'hFFFF);
        apb_read(4'd9, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL unmapped_read: got %h expected 0000", rd);
        end
`ifdef APB_TIMER_PSLVERR_EN
        tests_run++;
        if (last_slverr !== 1'b1) begin
            tests_failed++;
            $display("FAIL unmapped_slverr: got %b expected 1", last_slverr);
        end
        apb_read(4'd1, rd);
        tests_run++;
        if (last_slverr !== 1'b0) begin
            tests_failed++;
            $display("FAIL mapped_slverr: got %b expected 0", last_slverr);
        end
`endif
    endtask

    task automatic test_reset_mid_transfer();
        logic [15:0] rd;
        logic        seen;
        apb_write(4'd1, 16'h1234);
        seen = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 16'h0000; pwrite = 1'b1; pwdata = 16'h0001;
        @(posedge clk); #1;
        penable = 1'b1;
        preset  = 1'b1;
        @(negedge clk);
        seen = seen | (pready === 1'b1);
        @(posedge clk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | (pready === 1'b1);
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL abandoned_pready: got pulse=%b expected 0", seen);
        end
        apb_read(4'd0, rd);
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL abandoned_ctrl: got %h expected 0000", rd);
        end
        apb_read(4'd1, rd);
        tests_run++;
        if (rd !== 16'h0000 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_load_irq: got load=%h irq=%b expected 0000/0", rd, irq);
        end
    endtask

    initial begin
        preset  = 1'b1;
        paddr   = '0;
        pwrite  = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwdata  = '0;
`ifdef APB_TIMER_PSLVERR_EN
        last_slverr = 1'b0;
`endif
        test_reset();
        test_autoreload();
        test_oneshot();
        test_w1c_race();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 time units, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_timer_s.md
Name: apb_timer_s

Overview:
- APB responder peripheral: a 16-bit down-counting timer with prescaler, auto-reload and a level interrupt.
- Sits on one M_PSELx slot of the APB interconnect, e.g. window 0x80–0x8F.
- Receives the interconnect's shared M_PADDR/M_PWRITE/M_PENABLE/M_PWDATA plus its own select line; returns PRDATA/PREADY.
- Decodes only S_PADDR[3:0]; the interconnect owns window selection.

Parameters:
- BUS_WIDTH, 16, width of address, data and counter registers.
- PRESCALE, 4, S_PCLK cycles per counter tick; legal values ≥1, where 1 means a tick every cycle.
- WAIT_STATES, 1, access-phase cycles with PREADY low before completion; legal values 0..7.

Ports:
- S_PCLK  in  1  bus clock; all state changes on its rising edge.
- S_PRESET  in  1  synchronous, active-high reset.
- S_PADDR  in  BUS_WIDTH  address; only [3:0] decoded.
- S_PWRITE  in  1  1 = write, 0 = read.
- S_PSELx  in  1  slot select from interconnect.
- S_PENABLE  in  1  APB access-phase marker.
- S_PWDATA  in  BUS_WIDTH  write data.
- S_PRDATA  out  BUS_WIDTH  read data, registered.
- S_PREADY  out  1  transfer completion, registered.
- IRQ  out  1  timer interrupt, level, registered.

Behaviour:
- Register map, offset S_PADDR[3:0]:
  - 0 CTRL: [0] EN, [1] AUTO, [2] IE; other bits read 0.
  - 1 LOAD: reload value.
  - 2 VALUE: current count; a write loads the count directly.
  - 3 STAT: [0] EXP, write-1-to-clear.
  - Offsets 4–15: read 0, writes ignored.
- Reset (S_PRESET=1 at an edge): all registers 0, prescaler 0, bus FSM to IDLE, S_PRDATA=0, S_PREADY=0, IRQ=0.
  - Reset mid-transfer abandons the transfer; no register write occurs.
- Bus FSM states IDLE, WAIT, DONE:
  - IDLE: S_PSELx & ~S_PENABLE (setup) → WAIT, loading the wait counter with WAIT_STATES. If WAIT_STATES=0, go directly to DONE instead.
  - WAIT: while S_PSELx & S_PENABLE, decrement the wait counter; at 0 → DONE. S_PSELx dropping in WAIT → IDLE, no side effects.
  - DONE: S_PREADY=1 for exactly one cycle. Writes commit at this edge. S_PRDATA holds the read value captured on entry to DONE. Then → IDLE.
  - S_PRDATA returns to 0 in IDLE. Write transfers drive S_PRDATA=0.
- Minimum transfer latency: setup cycle + WAIT_STATES + 1 access cycle with PREADY high.
- Counter:
  - Prescaler counts 0..PRESCALE-1 while EN=1; a tick occurs on wrap to 0.
  - Prescaler clears whenever EN is written (0 or 1).
  - On a tick with VALUE≠0: VALUE decrements.
  - On a tick with VALUE=0: EXP←1. If AUTO, VALUE←LOAD; else EN←0 and VALUE stays 0.
  - EN=0: counter and prescaler frozen.
- Simultaneous events:
  - APB write to VALUE in the same cycle as a tick: the write wins and the tick is lost.
  - STAT W1C in the same cycle as an expiry: set wins, EXP stays 1.
  - Write to CTRL clearing EN in the same cycle as an expiry: EXP still sets, EN ends 0.
  - Write to LOAD in the same cycle as an auto-reload: reload uses the old LOAD.
- IRQ is registered EXP & IE, one cycle after either changes.
- Width rule: all arithmetic is BUS_WIDTH-bit unsigned; no wrap below 0 (the 0 case is handled above).

Optional Feature:
- Macro APB_TIMER_PSLVERR_EN.
- Defined: adds output S_PSLVERR (1 bit, reset 0). It is asserted together with S_PREADY in DONE when the offset is 4–15 or when writing STAT with bit0=0. Register side effects are unchanged.
- Undefined: no S_PSLVERR port; unmapped accesses complete normally.

Test Plan:
- Reset, then read all offsets 0–3 → S_PRDATA=0x0000 each; PREADY high exactly 1 cycle, 2 cycles after setup (WAIT_STATES=1); IRQ=0.
- Write LOAD=0x0003, VALUE=0x0003, CTRL=0x0007 (PRESCALE=4) → VALUE reads 2,1,0 at 4-cycle ticks; next tick gives EXP=1, VALUE=3, IRQ=1 one cycle later.
- CTRL=0x0001 (one-shot), VALUE=0x0001 → after 2 ticks EXP=1, CTRL reads 0x0000, VALUE=0x0000, IRQ stays 0.
- Write STAT=0x0001 in the cycle EXP sets → EXP reads 1; a later STAT=0x0001 write → EXP=0, IRQ drops next cycle.
- Write VALUE=0x00FF timed to coincide with a tick → VALUE reads 0x00FF, not 0x00FE; read of offset 0x9 → 0x0000 (PSLVERR=1 if APB_TIMER_PSLVERR_EN).
- Assert S_PRESET during WAIT of a CTRL=0x0001 write → CTRL reads 0, FSM IDLE, PREADY never pulses for that transfer.
